// File: rtl/datapath_pipe.sv
// datapath_pipe: three-stage (OF -> EX/C -> WB) register-file datapath with
// a B-operand shifter, 4-op ALU, {V,N,Z} status and full operand forwarding.
module datapath_pipe #(
    parameter int DATA_W  = 16,
    parameter int REG_CNT = 8,
    parameter int PC_W    = 8,
    localparam int AW     = $clog2(REG_CNT)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic              stall,
    input  logic [AW-1:0]     rn,
    input  logic [AW-1:0]     rm,
    input  logic [AW-1:0]     rd,
    input  logic [1:0]        shift,
    input  logic              asel,
    input  logic              bsel,
    input  logic [1:0]        aluop,
    input  logic [1:0]        wb_sel,
    input  logic              wr_en,
    input  logic              set_status,
    input  logic [DATA_W-1:0] sximm5,
    input  logic [DATA_W-1:0] sximm8,
    input  logic [PC_W-1:0]   pc,
    input  logic [DATA_W-1:0] mdata,
    output logic [DATA_W-1:0] result,
    output logic [2:0]        status,
    output logic              wb_valid,
    output logic [AW-1:0]     wb_addr,
    output logic [DATA_W-1:0] wb_data,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] sximm5;
        logic [DATA_W-1:0] sximm8;
        logic [PC_W-1:0]   pc;
        logic [AW-1:0]     rd;
        logic [1:0]        shift;
        logic [1:0]        aluop;
        logic [1:0]        wb_sel;
        logic              asel;
        logic              bsel;
        logic              wr_en;
        logic              set_status;
    } of_t;

    localparam int M = DATA_W - 1;

    logic [REG_CNT-1:0][DATA_W-1:0] regs;
    of_t                            of_q;
    logic [1:0]                     vld_pipe;   // [0] OF holds an op, [1] C holds an op awaiting WB
    logic [AW-1:0]                  wb_rd;
    logic                           wb_wr_en;
    logic                           wb_we;
    logic [DATA_W-1:0]              b_sh, ain, bin, alu, ex_val, op_a, op_b;
    logic                           ovf;

    // Shifter, ALU, overflow and EX result select for the op sitting in OF
    always_comb begin
        unique case (of_q.shift)
            2'b00:   b_sh = of_q.b;
            2'b01:   b_sh = {of_q.b[M-1:0], 1'b0};
            2'b10:   b_sh = {1'b0, of_q.b[M:1]};
            default: b_sh = {of_q.b[M], of_q.b[M:1]};
        endcase
        ain = of_q.asel ? '0 : of_q.a;
        bin = of_q.bsel ? of_q.sximm5 : b_sh;
        ovf = 1'b0;
        unique case (of_q.aluop)
            2'b00: begin
                alu = ain + bin;
                ovf = (ain[M] == bin[M]) && (alu[M] != ain[M]);
            end
            2'b01: begin
                alu = ain - bin;
                ovf = (ain[M] != bin[M]) && (alu[M] != ain[M]);
            end
            2'b10:   alu = ain & bin;
            default: alu = ~bin;
        endcase
        unique case (of_q.wb_sel)
            2'b00:   ex_val = alu;
            2'b01:   ex_val = of_q.sximm8;
            2'b10:   ex_val = DATA_W'(of_q.pc);
            default: ex_val = mdata;
        endcase
    end

    // Operand fetch: youngest in-flight producer wins over older one and the file
    always_comb begin
        op_a = regs[rn];
        if (vld_pipe[1] && wb_wr_en && wb_rd == rn) op_a = result;
        if (vld_pipe[0] && of_q.wr_en && of_q.rd == rn) op_a = ex_val;
        op_b = regs[rm];
        if (vld_pipe[1] && wb_wr_en && wb_rd == rm) op_b = result;
        if (vld_pipe[0] && of_q.wr_en && of_q.rd == rm) op_b = ex_val;
    end

    // OF stage capture and valid shift register; stall freezes both
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            of_q     <= '0;
        end else if (!stall) begin
            vld_pipe <= {vld_pipe[0], in_valid};
            if (in_valid)
                of_q <= '{a: op_a, b: op_b, sximm5: sximm5, sximm8: sximm8, pc: pc,
                          rd: rd, shift: shift, aluop: aluop, wb_sel: wb_sel,
                          asel: asel, bsel: bsel, wr_en: wr_en, set_status: set_status};
        end
    end

    // EX stage: load C, status and writeback tag; bubbles leave C untouched
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result   <= '0;
            status   <= '0;
            wb_rd    <= '0;
            wb_wr_en <= 1'b0;
        end else if (!stall && vld_pipe[0]) begin
            result   <= ex_val;
            wb_rd    <= of_q.rd;
            wb_wr_en <= of_q.wr_en;
            if (of_q.set_status) status <= {ovf, alu[M], alu == '0};
        end
    end

    assign wb_we = vld_pipe[1] && wb_wr_en && !stall;

    // WB stage: register file write from C
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) regs <= '0;
        else if (wb_we) regs[wb_rd] <= result;
    end

    assign wb_valid = wb_we;
    assign wb_addr  = wb_we ? wb_rd : '0;
    assign wb_data  = wb_we ? result : '0;
    assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_datapath_pipe.sv
// Directed bench for datapath_pipe: default 16-bit instance plus a 32-bit,
// 16-register instance for the wide-parameter arithmetic-shift case.
module tb_datapath_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    int          checks = 0;
    int          errors = 0;

    // default instance
    logic        in_valid, asel, bsel, wr_en, set_status, wb_valid;
    logic [2:0]  rn, rm, rd, wb_addr, dbg_addr, status;
    logic [1:0]  shift, aluop, wb_sel;
    logic [15:0] sximm5, sximm8, mdata, result, wb_data, dbg_data;
    logic [7:0]  pc;

    // wide instance
    logic        w_in_valid, w_asel, w_bsel, w_wr_en, w_set_status, w_wb_valid;
    logic [3:0]  w_rn, w_rm, w_rd, w_wb_addr, w_dbg_addr;
    logic [2:0]  w_status;
    logic [1:0]  w_shift, w_aluop, w_wb_sel;
    logic [31:0] w_sximm5, w_sximm8, w_mdata, w_result, w_wb_data, w_dbg_data;
    logic [7:0]  w_pc;

    always #5 clk = ~clk;

    datapath_pipe dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .stall(stall),
        .rn(rn), .rm(rm), .rd(rd), .shift(shift), .asel(asel), .bsel(bsel),
        .aluop(aluop), .wb_sel(wb_sel), .wr_en(wr_en), .set_status(set_status),
        .sximm5(sximm5), .sximm8(sximm8), .pc(pc), .mdata(mdata),
        .result(result), .status(status), .wb_valid(wb_valid), .wb_addr(wb_addr),
        .wb_data(wb_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    datapath_pipe #(.DATA_W(32), .REG_CNT(16), .PC_W(8)) dut_w (
        .clk(clk), .reset_n(reset_n), .in_valid(w_in_valid), .stall(stall),
        .rn(w_rn), .rm(w_rm), .rd(w_rd), .shift(w_shift), .asel(w_asel), .bsel(w_bsel),
        .aluop(w_aluop), .wb_sel(w_wb_sel), .wr_en(w_wr_en), .set_status(w_set_status),
        .sximm5(w_sximm5), .sximm8(w_sximm8), .pc(w_pc), .mdata(w_mdata),
        .result(w_result), .status(w_status), .wb_valid(w_wb_valid), .wb_addr(w_wb_addr),
        .wb_data(w_wb_data), .dbg_addr(w_dbg_addr), .dbg_data(w_dbg_data)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [2:0] n, input logic [2:0] m, input logic [2:0] d,
                          input logic [1:0] sh, input logic as, input logic bs,
                          input logic [1:0] op, input logic [1:0] ws,
                          input logic we, input logic ss,
                          input logic [15:0] s5, input logic [15:0] s8);
        in_valid = 1'b1; rn = n; rm = m; rd = d; shift = sh; asel = as; bsel = bs;
        aluop = op; wb_sel = ws; wr_en = we; set_status = ss; sximm5 = s5; sximm8 = s8;
    endtask

    task automatic idle;
        in_valid = 1'b0; wr_en = 1'b0; set_status = 1'b0;
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [15:0] v);
        dbg_addr = a;
        #1;
        v = dbg_data;
    endtask

    task automatic test_reset;
        logic [15:0] v;
        reset_n = 1'b0;
        tick; tick;
        checks++;
        if (result !== 16'h0 || status !== 3'b000 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: result=%h status=%b wb_valid=%b, want 0000/000/0", result, status, wb_valid);
        end
        reset_n = 1'b1;
        set_op(0, 0, 1, 2'b00, 0, 0, 2'b00, 2'b01, 1, 0, 16'h0, 16'h0003); tick;
        set_op(0, 0, 2, 2'b00, 0, 0, 2'b00, 2'b01, 1, 0, 16'h0, 16'h0004); tick;
        idle;
        checks++;
        if (result !== 16'h0003) begin
            errors++;
            $display("FAIL reset_pre_result: got %h want 0003", result);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (result !== 16'h0 || status !== 3'b000 || wb_valid !== 1'b0 ||
            wb_addr !== 3'd0 || wb_data !== 16'h0 || w_result !== 32'h0) begin
            errors++;
            $display("FAIL reset_async: result=%h status=%b wb_valid=%b wb_addr=%0d wb_data=%h", result, status, wb_valid, wb_addr, wb_data);
        end
        for (int i = 0; i < 8; i++) begin
            rd_reg(3'(i), v);
            checks++;
            if (v !== 16'h0) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h want 0000", i, v);
            end
        end
        tick; tick;
        reset_n = 1'b1;
        tick; tick;
        rd_reg(3'd1, v);
        checks++;
        if (v !== 16'h0) begin
            errors++;
            $display("FAIL reset_discard_r1: got %h want 0000", v);
        end
    endtask

    task automatic test_forward;
        logic [15:0] v;
        set_op(0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b01, 1, 0, 16'h0, 16'h0007); tick;
        set_op(0, 0, 1, 2'b00, 0, 0, 2'b00, 2'b01, 1, 0, 16'h0, 16'h0002); tick;
        set_op(1, 0, 2, 2'b01, 0, 0, 2'b00, 2'b00, 1, 0, 16'h0, 16'h0); tick;
        idle; tick;
        checks++;
        if (result !== 16'd16) begin
            errors++;
            $display("FAIL fwd_result: got %h want 0010", result);
        end
        checks++;
        if (wb_valid !== 1'b1 || wb_addr !== 3'd2 || wb_data !== 16'd16) begin
            errors++;
            $display("FAIL fwd_wb_port: valid=%b addr=%0d data=%h want 1/2/0010", wb_valid, wb_addr, wb_data);
        end
        tick; tick;
        rd_reg(3'd2, v);
        checks++;
        if (v !== 16'd16) begin
            errors++;
            $display("FAIL fwd_r2: got %h want 0010", v);
        end
        rd_reg(3'd0, v);
        checks++;
        if (v !== 16'd7) begin
            errors++;
            $display("FAIL fwd_r0: got %h want 0007", v);
        end
    endtask

    task automatic test_overflow;
        mdata = 16'h7FFF;
        set_op(0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b11, 1, 0, 16'h0, 16'h0); tick;
        set_op(0, 0, 0, 2'b00, 0, 1, 2'b00, 2'b00, 0, 1, 16'h0001, 16'h0); tick;
        idle; tick;
        checks++;
        if (result !== 16'h8000 || status !== 3'b110) begin
            errors++;
            $display("FAIL overflow: result=%h status=%b want 8000/110", result, status);
        end
        tick; tick;
    endtask

    task automatic test_status_hold;
        set_op(3, 3, 3, 2'b00, 0, 0, 2'b01, 2'b00, 0, 1, 16'h0, 16'h0); tick;
        set_op(0, 0, 3, 2'b00, 0, 0, 2'b10, 2'b00, 0, 0, 16'h0, 16'h0); tick;
        checks++;
        if (result !== 16'h0 || status !== 3'b001) begin
            errors++;
            $display("FAIL status_sub: result=%h status=%b want 0000/001", result, status);
        end
        idle; tick;
        checks++;
        if (result !== 16'h7FFF || status !== 3'b001) begin
            errors++;
            $display("FAIL status_hold: result=%h status=%b want 7fff/001", result, status);
        end
    endtask

    task automatic test_alu_misc;
        pc = 8'hA5;
        set_op(0, 0, 3, 2'b00, 0, 0, 2'b11, 2'b00, 0, 1, 16'h0, 16'h0); tick;
        set_op(0, 0, 3, 2'b10, 1, 0, 2'b00, 2'b00, 0, 0, 16'h0, 16'h0); tick;
        checks++;
        if (result !== 16'h8000 || status !== 3'b010) begin
            errors++;
            $display("FAIL alu_not: result=%h status=%b want 8000/010", result, status);
        end
        set_op(0, 0, 3, 2'b00, 0, 0, 2'b00, 2'b10, 0, 0, 16'h0, 16'h0); tick;
        checks++;
        if (result !== 16'h3FFF) begin
            errors++;
            $display("FAIL alu_lsr: got %h want 3fff", result);
        end
        idle; tick;
        checks++;
        if (result !== 16'h00A5 || status !== 3'b010) begin
            errors++;
            $display("FAIL alu_pc: result=%h status=%b want 00a5/010", result, status);
        end
    endtask

    task automatic test_same_addr;
        logic [15:0] v;
        set_op(0, 0, 7, 2'b00, 0, 0, 2'b00, 2'b01, 1, 0, 16'h0, 16'h0001); tick;
        set_op(0, 0, 7, 2'b00, 0, 0, 2'b00, 2'b01, 1, 0, 16'h0, 16'h0002); tick;
        idle; tick; tick; tick;
        rd_reg(3'd7, v);
        checks++;
        if (v !== 16'h0002) begin
            errors++;
            $display("FAIL same_addr_r7: got %h want 0002", v);
        end
    endtask

    task automatic test_stall;
        logic [15:0] v;
        set_op(0, 0, 4, 2'b00, 0, 0, 2'b00, 2'b01, 1, 0, 16'h0, 16'h0005); tick;
        set_op(0, 0, 5, 2'b00, 0, 0, 2'b00, 2'b01, 1, 0, 16'h0, 16'h0009); tick;
        set_op(4, 5, 6, 2'b00, 0, 0, 2'b00, 2'b00, 1, 1, 16'h0, 16'h0);
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick;
            rd_reg(3'd4, v);
            checks++;
            if (result !== 16'h0005 || status !== 3'b010 || wb_valid !== 1'b0 || v !== 16'h0) begin
                errors++;
                $display("FAIL stall_cycle%0d: result=%h status=%b wb_valid=%b r4=%h want 0005/010/0/0000", c, result, status, wb_valid, v);
            end
        end
        stall = 1'b0;
        tick;
        idle;
        checks++;
        if (result !== 16'h0009) begin
            errors++;
            $display("FAIL stall_resume_b: got %h want 0009", result);
        end
        tick;
        checks++;
        if (result !== 16'd14 || status !== 3'b000) begin
            errors++;
            $display("FAIL stall_resume_c: result=%h status=%b want 000e/000", result, status);
        end
        tick; tick;
        rd_reg(3'd6, v);
        checks++;
        if (v !== 16'd14) begin
            errors++;
            $display("FAIL stall_r6: got %h want 000e", v);
        end
        rd_reg(3'd4, v);
        checks++;
        if (v !== 16'd5) begin
            errors++;
            $display("FAIL stall_r4: got %h want 0005", v);
        end
    endtask

    task automatic test_wide;
        w_mdata = 32'h8000_0000;
        w_in_valid = 1'b1; w_rd = 4'd15; w_wb_sel = 2'b11; w_wr_en = 1'b1; w_set_status = 1'b0;
        tick;
        w_rm = 4'd15; w_rd = 4'd0; w_shift = 2'b11; w_asel = 1'b1; w_aluop = 2'b00;
        w_wb_sel = 2'b00; w_wr_en = 1'b0; w_set_status = 1'b1;
        tick;
        w_in_valid = 1'b0; w_set_status = 1'b0;
        tick;
        checks++;
        if (w_result !== 32'hC000_0000 || w_status !== 3'b010) begin
            errors++;
            $display("FAIL wide_asr: result=%h status=%b want c0000000/010", w_result, w_status);
        end
        tick; tick;
        w_dbg_addr = 4'd15;
        #1;
        checks++;
        if (w_dbg_data !== 32'h8000_0000) begin
            errors++;
            $display("FAIL wide_r15: got %h want 80000000", w_dbg_data);
        end
    endtask

    initial begin
        stall = 1'b0; mdata = '0; pc = '0; dbg_addr = '0;
        set_op(0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 16'h0, 16'h0);
        idle;
        w_in_valid = 1'b0; w_rn = '0; w_rm = '0; w_rd = '0; w_shift = '0; w_asel = 1'b0;
        w_bsel = 1'b0; w_aluop = '0; w_wb_sel = '0; w_wr_en = 1'b0; w_set_status = 1'b0;
        w_sximm5 = '0; w_sximm8 = '0; w_pc = '0; w_mdata = '0; w_dbg_addr = '0;
        test_reset;
        test_forward;
        test_overflow;
        test_status_hold;
        test_alu_misc;
        test_same_addr;
        test_stall;
        test_wide;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
